// File: rtl/trng_collector.sv
// trng_collector: consumer side of the ring-oscillator TRNG.
// Synchronises the raw bit stream and runs a repetition-count health test on it.
// Optionally removes bias with a von Neumann corrector.
// Packs accepted bits MSB-first into words, which leave through a valid/ready port.
module trng_collector #(
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned WARMUP_BITS = 64,
  parameter int unsigned REP_LIMIT   = 32,
  parameter bit          DEBIAS      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  trng_out_i,
  output logic                  trng_en_o,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  health_fail_o,
  input  logic                  clear_fail_i
);

  localparam int unsigned CntW  = $clog2(WORD_WIDTH + 1);
  localparam int unsigned WarmW = $clog2(WARMUP_BITS + 1);

  localparam logic [CntW-1:0]  WordCnt  = CntW'(WORD_WIDTH);
  localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_BITS - 1);
  localparam logic [7:0]       RepLim   = 8'(REP_LIMIT);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWarmup  = 2'd1;
  localparam logic [1:0] StCollect = 2'd2;
  localparam logic [1:0] StFail    = 2'd3;

  // Synchroniser
  logic sync1_q, sync2_q;

  // FSM and datapath
  logic [1:0]            state_q, state_d;
  logic [WarmW-1:0]      warm_cnt_q, warm_cnt_d;
  logic                  pair_vld_q, pair_vld_d;
  logic                  pair_a_q, pair_a_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;

  // Health test
  logic [7:0] rep_cnt_q, rep_cnt_d, rep_upd;
  logic       last_bit_q, last_bit_d;
  logic       fail_q, fail_d;
  logic       trip;

  // Corrector outputs
  logic emit, emit_bit, pair_vld_nx, pair_a_nx;

  logic raw_vld, disable_req, buf_free;

  // The oscillators run in every state except idle, so a raw bit is present on each such cycle.
  assign raw_vld     = (state_q != StIdle);
  // Dropping enable stops warmup/collection at once; a failed source stays on until cleared.
  assign disable_req = ((state_q == StWarmup) || (state_q == StCollect)) && !enable_i;
  assign buf_free    = !valid_q || ready_i;

  assign trng_en_o     = raw_vld;
  assign word_o        = word_q;
  assign valid_o       = valid_q;
  assign health_fail_o = fail_q;

  // Repetition-count health test on the synchronised raw bit.
  always_comb begin
    rep_upd = rep_cnt_q;
    trip    = 1'b0;
    if (raw_vld && !disable_req) begin
      // A count of zero means there is no previous bit to compare with.
      if ((rep_cnt_q != 8'd0) && (sync2_q == last_bit_q)) begin
        rep_upd = (rep_cnt_q >= RepLim) ? rep_cnt_q : rep_cnt_q + 8'd1;
      end else begin
        rep_upd = 8'd1;
      end
      trip = (rep_upd >= RepLim);
    end
    // A trip in the same cycle as a clear keeps the counter and the flag.
    rep_cnt_d  = (disable_req || (clear_fail_i && !trip)) ? 8'd0 : rep_upd;
    last_bit_d = (raw_vld && !disable_req) ? sync2_q : last_bit_q;
    fail_d     = trip | (fail_q & ~clear_fail_i);
  end

  // Von Neumann pairing (or pass-through) of the current raw bit.
  always_comb begin
    emit        = 1'b0;
    emit_bit    = sync2_q;
    pair_vld_nx = pair_vld_q;
    pair_a_nx   = pair_a_q;
    if (DEBIAS) begin
      if (!pair_vld_q) begin
        pair_vld_nx = 1'b1;
        pair_a_nx   = sync2_q;
      end else begin
        // 01 gives 0, 10 gives 1: the emitted bit is the first of the pair.
        pair_vld_nx = 1'b0;
        emit        = (pair_a_q != sync2_q);
        emit_bit    = pair_a_q;
      end
    end else begin
      emit = 1'b1;
    end
  end

  // FSM, word packing and output buffer next-state.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    pair_vld_d = pair_vld_q;
    pair_a_d   = pair_a_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_d     = word_q;
    valid_d    = valid_q & ~ready_i;

    case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d    = StWarmup;
          warm_cnt_d = '0;
        end
      end

      StWarmup, StCollect: begin
        if (disable_req || trip) begin
          // Disable keeps a pending word; a health failure discards it.
          state_d    = disable_req ? StIdle : StFail;
          if (!disable_req) begin
            valid_d = 1'b0;
          end
          warm_cnt_d = '0;
          pair_vld_d = 1'b0;
          pair_a_d   = 1'b0;
          shreg_d    = '0;
          bit_cnt_d  = '0;
        end else if (state_q == StWarmup) begin
          if (warm_cnt_q == WarmLast) begin
            state_d    = StCollect;
            warm_cnt_d = '0;
            pair_vld_d = 1'b0;
          end else begin
            warm_cnt_d = warm_cnt_q + WarmW'(1);
          end
        end else begin
          pair_vld_d = pair_vld_nx;
          pair_a_d   = pair_a_nx;
          // A full shifter waiting on the buffer drops new bits; pair phase still advances.
          if (emit && (bit_cnt_q != WordCnt)) begin
            shreg_d   = {shreg_q[WORD_WIDTH-2:0], emit_bit};
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
          if ((bit_cnt_d == WordCnt) && buf_free) begin
            word_d    = shreg_d;
            valid_d   = 1'b1;
            bit_cnt_d = '0;
          end
        end
      end

      StFail: begin
        if (clear_fail_i && !trip) begin
          state_d    = enable_i ? StWarmup : StIdle;
          warm_cnt_d = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Two-flop synchroniser for the asynchronous oscillator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= trng_out_i;
      sync2_q <= sync1_q;
    end
  end

  // FSM, datapath and output buffer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      warm_cnt_q <= '0;
      pair_vld_q <= 1'b0;
      pair_a_q   <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      pair_vld_q <= pair_vld_d;
      pair_a_q   <= pair_a_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
    end
  end

  // Health test state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q  <= 8'd0;
      last_bit_q <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      last_bit_q <= last_bit_d;
      fail_q     <= fail_d;
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Testbench for trng_collector: directed scenarios plus randomized traffic.
// A queue-based reference model predicts words; a monitor checks handshakes and flags.
module tb_trng_collector;

  localparam int W   = 8;
  localparam int WB  = 4;
  localparam int LIM = 8;
  localparam bit DB  = 1'b1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable_i = 1'b0;
  logic         trng_out_i = 1'b0;
  logic         ready_i = 1'b0;
  logic         clear_fail_i = 1'b0;
  logic         trng_en_o;
  logic [W-1:0] word_o;
  logic         valid_o;
  logic         health_fail_o;

  int n_tests = 0;
  int n_fails = 0;

  trng_collector #(
    .WORD_WIDTH (W),
    .WARMUP_BITS(WB),
    .REP_LIMIT  (LIM),
    .DEBIAS     (DB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .trng_out_i   (trng_out_i),
    .trng_en_o    (trng_en_o),
    .word_o       (word_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .health_fail_o(health_fail_o),
    .clear_fail_i (clear_fail_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // States: 0 idle, 1 warmup, 2 collect, 3 fail.
  int           m_st, m_warm, m_run;
  bit           m_d1, m_d2, m_last, m_fail, m_havea, m_a, m_vld;
  bit           m_acc[$];
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    m_st = 0; m_warm = 0; m_run = 0;
    m_d1 = 0; m_d2 = 0; m_last = 0; m_fail = 0; m_havea = 0; m_a = 0; m_vld = 0;
    m_acc.delete();
    exp_q.delete();
  endtask

  task automatic flush_collect();
    m_acc.delete();
    m_havea = 0;
    m_warm  = 0;
  endtask

  task automatic model_step(input bit en, input bit din, input bit rdy, input bit clr);
    bit raw, rv, dis, trip, e, ebit, nvld, free;
    int run_n;
    logic [W-1:0] wd;
    raw  = m_d2;
    m_d2 = m_d1;
    m_d1 = din;
    rv   = (m_st != 0);
    dis  = (m_st == 1 || m_st == 2) && !en;
    trip = 0;
    run_n = m_run;
    if (rv && !dis) begin
      if (m_run > 0 && raw == m_last) run_n = (m_run < LIM) ? m_run + 1 : m_run;
      else run_n = 1;
      m_last = raw;
      trip = (run_n >= LIM);
    end
    if (dis || (clr && !trip)) run_n = 0;
    m_run = run_n;
    if (trip) m_fail = 1;
    else if (clr) m_fail = 0;
    nvld = m_vld && !rdy;
    free = !m_vld || rdy;
    case (m_st)
      0: if (en) begin m_st = 1; m_warm = 0; end
      1, 2: begin
        if (dis) begin
          m_st = 0;
          flush_collect();
        end else if (trip) begin
          if (nvld && exp_q.size() > 0) void'(exp_q.pop_back());
          nvld = 0;
          m_st = 3;
          flush_collect();
        end else if (m_st == 1) begin
          m_warm++;
          if (m_warm == WB) begin m_st = 2; m_warm = 0; m_havea = 0; end
        end else begin
          e = 0; ebit = 0;
          if (DB) begin
            if (!m_havea) begin m_a = raw; m_havea = 1; end
            else begin
              m_havea = 0;
              if (m_a != raw) begin e = 1; ebit = m_a; end
            end
          end else begin
            e = 1; ebit = raw;
          end
          if (e && m_acc.size() < W) m_acc.push_back(ebit);
          if (m_acc.size() == W && free) begin
            wd = '0;
            for (int i = 0; i < W; i++) wd[W-1-i] = m_acc[i];
            exp_q.push_back(wd);
            m_acc.delete();
            nvld = 1;
          end
        end
      end
      default: if (!trip && clr) begin m_st = en ? 1 : 0; m_warm = 0; end
    endcase
    m_vld = nvld;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(enable_i, trng_out_i, ready_i, clear_fail_i);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("valid_o", valid_o, m_vld);
        chk("health_fail_o", health_fail_o, m_fail);
        chk("trng_en_o", trng_en_o, (m_st != 0));
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fails++;
            $display("FAIL sb_word: got %0h, expected no word pending at %0t", word_o, $time);
          end else begin
            exp_w = exp_q.pop_front();
            chk("sb_word", word_o, exp_w);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic en, input logic b, input logic rdy, input logic clr);
    enable_i     = en;
    trng_out_i   = b;
    ready_i      = rdy;
    clear_fail_i = clr;
    @(posedge clk);
    #1;
  endtask

  // Enable from idle; three filler slots so the first data slot lands on the first collect bit.
  task automatic start_enable();
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
  endtask

  task automatic feed_byte(input logic [7:0] b, input logic rdy, input bit noisy);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      cyc(1, b[i], rdy, 0);
      cyc(1, !b[i], rdy, 0);
      if (noisy && $urandom_range(0, 1) == 1) begin
        x = 1'($urandom_range(0, 1));
        cyc(1, x, rdy, 0);
        cyc(1, x, rdy, 0);
      end
    end
  endtask

  // Two discarded pairs (00, 11) to let the pipeline drain without emitting bits.
  task automatic pad4(input logic rdy);
    cyc(1, 0, rdy, 0);
    cyc(1, 0, rdy, 0);
    cyc(1, 1, rdy, 0);
    cyc(1, 1, rdy, 0);
  endtask

  initial begin
    bit en_state;
    int rdy_pct;

    // Reset state
    #2;
    chk("rst_trng_en", trng_en_o, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_word", word_o, 8'h00);
    chk("rst_health", health_fail_o, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk("idle_trng_en", trng_en_o, 1'b0);

    // 1: basic von Neumann word
    start_enable();
    feed_byte(8'hB2, 0, 0);
    pad4(0);
    chk("t1_valid", valid_o, 1'b1);
    chk("t1_word", word_o, 8'hB2);

    // 3: buffer busy; second word held in the shifter, third dropped
    feed_byte(8'h3C, 0, 0);
    feed_byte(8'hA5, 0, 0);
    pad4(0);
    chk("t3_hold_word", word_o, 8'hB2);
    chk("t3_hold_valid", valid_o, 1'b1);
    cyc(1, 0, 1, 0);
    chk("t3_second_word", word_o, 8'h3C);
    chk("t3_second_valid", valid_o, 1'b1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    chk("t3_drained", valid_o, 1'b0);

    // 2: discarded pairs interleaved
    feed_byte(8'hB2, 0, 1);
    pad4(0);
    chk("t2_word", word_o, 8'hB2);
    chk("t2_valid", valid_o, 1'b1);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);

    // 4: health trip with a word pending, then clear
    feed_byte(8'h5A, 0, 0);
    pad4(0);
    chk("t4_pending", valid_o, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1'(i % 2), 0, 0);
    chk("t4_flag", health_fail_o, 1'b1);
    chk("t4_valid_dropped", valid_o, 1'b0);
    chk("t4_trng_en", trng_en_o, 1'b1);
    cyc(1, 1, 0, 1);
    chk("t4_flag_cleared", health_fail_o, 1'b0);
    chk("t4_warmup_en", trng_en_o, 1'b1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t4_idle", trng_en_o, 1'b0);

    // 5: disable mid-word with a word pending, then re-enable
    start_enable();
    feed_byte(8'hC3, 0, 0);
    pad4(0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t5_trng_en_off", trng_en_o, 1'b0);
    chk("t5_valid_kept", valid_o, 1'b1);
    chk("t5_word_kept", word_o, 8'hC3);
    cyc(0, 1, 1, 0);
    chk("t5_read", valid_o, 1'b0);
    start_enable();
    feed_byte(8'hB2, 0, 0);
    pad4(0);
    chk("t5_rewarm_word", word_o, 8'hB2);
    chk("t5_rewarm_valid", valid_o, 1'b1);

    // 6: async reset mid-word with a word pending
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_trng_en", trng_en_o, 1'b0);
    chk("t6_valid", valid_o, 1'b0);
    chk("t6_word", word_o, 8'h00);
    chk("t6_health", health_fail_o, 1'b0);
    enable_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_enable();
    feed_byte(8'h96, 0, 0);
    pad4(0);
    chk("t6_word_after", word_o, 8'h96);
    chk("t6_valid_after", valid_o, 1'b1);

    // Randomized traffic against the model
    en_state = 1;
    for (int seg = 0; seg < 3; seg++) begin
      rdy_pct = (seg == 0) ? 50 : ((seg == 1) ? 12 : 100);
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 199) == 0) en_state = !en_state;
        cyc(en_state, 1'($urandom_range(0, 1)), ($urandom_range(1, 100) <= rdy_pct),
            ($urandom_range(0, 29) == 0));
      end
    end
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
